awb_gain_engine: RTL

- Parametrised gray-world auto-white-balance gain engine; the successor to the fixed 8-bit, three-divider calculator.
- Sits after the Bayer pixel stream and ahead of the AWB gain multiplier in the ISP pipe.
- Accumulates per-channel Bayer sums over a frame, snapshots them on frame end and clears the accumulators, so the next frame is collected while gains are computed.
- Computes fixed-point gains with one shared, time-multiplexed restoring divider.
- Adds saturation, gain clamping, a divide-by-zero guard, a bypass mode and atomic gain update.

---
 rtl/awb_pkg.sv | 22 ++
 rtl/awb_restoring_div.sv | 78 +++++++
 rtl/awb_gain_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/awb_pkg.sv
// Shared definitions for the gray-world AWB gain engine: FSM encoding,
// Bayer tag bit positions and the fixed-point unity helper.
package awb_pkg;

    typedef enum logic [2:0] {
        ST_ACC,
        ST_DIV_R,
        ST_DIV_G,
        ST_DIV_B,
        ST_DONE
    } awb_state_t;

    localparam int BAYER_G0 = 0;
    localparam int BAYER_B  = 1;
    localparam int BAYER_R  = 2;
    localparam int BAYER_G1 = 3;

    function automatic int unity(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/awb_restoring_div.sv
// Sequential restoring divider: one setup cycle, then one quotient bit per
// cycle MSB first; divide-by-zero and quotient-overflow resolve in setup.
module awb_restoring_div
    import awb_pkg::*;
#(
    parameter int NW   = 37,
    parameter int DVW  = 32,
    parameter int QW   = 8,
    parameter int FRAC = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NW-1:0]   dividend,
    input  logic [DVW-1:0]  divisor,
    output logic [QW-1:0]   quotient,
    output logic            done
);

    localparam int XW = ((NW > DVW + QW) ? NW : DVW + QW) + 1;
    localparam int CW = $clog2(QW + 1);
    localparam logic [QW-1:0] UNITY = QW'(unity(FRAC));

    logic [XW-1:0] rem_reg;
    logic [XW-1:0] dsh_reg;
    logic [QW-1:0] q_reg;
    logic [CW-1:0] cnt_reg;
    logic          run_reg;

    logic [XW-1:0] dividend_x;
    logic [XW-1:0] divisor_top;
    logic          quot_ovf;
    logic          rem_ge;

    assign dividend_x  = XW'(dividend);
    assign divisor_top = XW'(divisor) << QW;
    // Quotient would need more than QW bits: saturate without iterating.
    assign quot_ovf    = (dividend_x >= divisor_top);
    assign rem_ge      = (rem_reg >= dsh_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg <= '0;
            dsh_reg <= '0;
            q_reg   <= UNITY;
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (start) begin
            run_reg <= 1'b0;
            cnt_reg <= '0;
            if (divisor == '0) begin
                q_reg <= UNITY;
            end else if (quot_ovf) begin
                q_reg <= '1;
            end else begin
                rem_reg <= dividend_x;
                dsh_reg <= XW'(divisor) << (QW - 1);
                q_reg   <= '0;
                cnt_reg <= CW'(QW);
                run_reg <= 1'b1;
            end
        end else if (run_reg) begin
            if (rem_ge) begin
                rem_reg <= rem_reg - dsh_reg;
            end
            q_reg   <= {q_reg[QW-2:0], rem_ge};
            dsh_reg <= dsh_reg >> 1;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
                run_reg <= 1'b0;
            end
        end
    end

    assign quotient = q_reg;
    assign done     = ~run_reg;

endmodule

// File: rtl/awb_gain_engine.sv
// Gray-world AWB gain engine: per-channel Bayer sums per frame, snapshot at
// frame end, then R/G/B gains from one shared time-multiplexed divider.
module awb_gain_engine
    import awb_pkg::*;
#(
    parameter int DW       = 8,
    parameter int ACC_W    = 32,
    parameter int GW       = 8,
    parameter int FRAC     = 5,
    parameter int GAIN_MAX = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clken,
    input  logic [DW-1:0] din,
    input  logic [3:0]    bayer_state,
    input  logic          end_flag,
    input  logic          awb_en,
    output logic [GW-1:0] r_gain,
    output logic [GW-1:0] g_gain,
    output logic [GW-1:0] b_gain,
    output logic          gain_ready,
    output logic          busy,
    output logic          acc_ovf
);

    localparam int NW  = ACC_W + FRAC;
    localparam int AW1 = ACC_W + 1;
    localparam int SW  = $clog2(GW + 1);
    localparam logic [GW-1:0] UNITY = GW'(unity(FRAC));
    localparam logic [GW-1:0] GMAX  = GW'(GAIN_MAX);

    // Channel index: 0 = luma total k, 1 = R, 2 = G, 3 = B.
    logic [ACC_W-1:0] acc_reg  [4];
    logic [ACC_W-1:0] acc_next [4];
    logic [ACC_W-1:0] op_reg   [4];
    logic [DW+1:0]    ch_val   [4];
    logic [3:0]       ch_en;
    logic [3:0]       sat;
    logic             ovf_reg;
    logic             ovf_next;
    logic             op_ovf_reg;
    logic             bypass_reg;

    awb_state_t       state_reg, state_next;
    logic [SW-1:0]    slot_reg, slot_next;
    logic [GW-1:0]    r_stage_reg, g_stage_reg;

    logic             div_start;
    logic [ACC_W-1:0] div_divisor;
    logic [GW-1:0]    div_q;
    logic             div_done;

    function automatic logic [GW-1:0] clamp_gain(input logic [GW-1:0] q);
        return (q > GMAX) ? GMAX : q;
    endfunction

    assign ch_en[0] = clken;
    assign ch_en[1] = clken & bayer_state[BAYER_R];
    assign ch_en[2] = clken & (bayer_state[BAYER_G0] | bayer_state[BAYER_G1]);
    assign ch_en[3] = clken & bayer_state[BAYER_B];
    assign ch_val[0] = {2'b00, din};
    assign ch_val[1] = {din, 2'b00};
    assign ch_val[2] = {1'b0, din, 1'b0};
    assign ch_val[3] = {din, 2'b00};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_acc
            logic [ACC_W:0] sum;
            assign sum          = {1'b0, acc_reg[gi]} + AW1'(ch_val[gi]);
            assign sat[gi]      = ch_en[gi] & sum[ACC_W];
            assign acc_next[gi] = !ch_en[gi] ? acc_reg[gi] :
                                  sat[gi]    ? '1 : sum[ACC_W-1:0];
        end
    endgenerate

    assign ovf_next = ovf_reg | (|sat);

    // Snapshot uses the next-state sums so a pixel coincident with end_flag
    // lands in the ending frame; accumulators restart from zero either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                acc_reg[i] <= '0;
                op_reg[i]  <= '0;
            end
            ovf_reg    <= 1'b0;
            op_ovf_reg <= 1'b0;
            bypass_reg <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                acc_reg[i] <= end_flag ? '0 : acc_next[i];
            end
            ovf_reg <= end_flag ? 1'b0 : ovf_next;
            if (end_flag && state_reg == ST_ACC) begin
                for (int i = 0; i < 4; i++) begin
                    op_reg[i] <= acc_next[i];
                end
                op_ovf_reg <= ovf_next;
                bypass_reg <= ~awb_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ACC;
            slot_reg  <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
        end
    end

    // Each divide state owns a fixed GW+1 cycle slot: setup then iterations.
    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        div_start  = 1'b0;
        case (state_reg)
            ST_ACC: begin
                slot_next = '0;
                if (end_flag) begin
                    state_next = awb_en ? ST_DIV_R : ST_DONE;
                end
            end
            ST_DIV_R, ST_DIV_G, ST_DIV_B: begin
                div_start = (slot_reg == '0);
                if (slot_reg == SW'(GW)) begin
                    slot_next = '0;
                    case (state_reg)
                        ST_DIV_R: state_next = ST_DIV_G;
                        ST_DIV_G: state_next = ST_DIV_B;
                        default:  state_next = ST_DONE;
                    endcase
                end else begin
                    slot_next = slot_reg + 1'b1;
                end
            end
            ST_DONE: state_next = ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    always_comb begin
        div_divisor = op_reg[1];
        case (state_reg)
            ST_DIV_G: div_divisor = op_reg[2];
            ST_DIV_B: div_divisor = op_reg[3];
            default:  div_divisor = op_reg[1];
        endcase
    end

    awb_restoring_div #(
        .NW   (NW),
        .DVW  (ACC_W),
        .QW   (GW),
        .FRAC (FRAC)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({op_reg[0], {FRAC{1'b0}}}),
        .divisor  (div_divisor),
        .quotient (div_q),
        .done     (div_done)
    );

    // The previous channel's quotient is still held during the next slot's
    // setup cycle, so it is staged there; B is taken straight from the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_reg <= UNITY;
            g_stage_reg <= UNITY;
            r_gain      <= UNITY;
            g_gain      <= UNITY;
            b_gain      <= UNITY;
            acc_ovf     <= 1'b0;
        end else begin
            if (div_done && slot_reg == '0 && state_reg == ST_DIV_G) begin
                r_stage_reg <= clamp_gain(div_q);
            end
            if (div_done && slot_reg == '0 && state_reg == ST_DIV_B) begin
                g_stage_reg <= clamp_gain(div_q);
            end
            if (state_reg == ST_DONE) begin
                r_gain  <= bypass_reg ? UNITY : r_stage_reg;
                g_gain  <= bypass_reg ? UNITY : g_stage_reg;
                b_gain  <= bypass_reg ? UNITY : clamp_gain(div_q);
                acc_ovf <= op_ovf_reg;
            end
        end
    end

    assign busy       = (state_reg == ST_DIV_R) || (state_reg == ST_DIV_G) ||
                        (state_reg == ST_DIV_B);
    assign gain_ready = (state_reg == ST_DONE);

endmodule
